// File: rtl/fp32_pkg.sv
// Shared FP32 types and constants for the sequential multiplier.
package fp32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam int          FP32_BIAS    = 127;
    localparam int          FP32_EXP_MAX = 255;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
    localparam logic [31:0] FP32_MAX_FIN = 32'h7F7FFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fp32_mul_state_e;

endpackage

// File: rtl/fp32_mant_mac.sv
// Shift-add 24x24 mantissa multiplier: retires BITS_PER_CYCLE multiplier
// bits per step into a 48-bit accumulator. Only the bits needed for
// normalisation (prod[47:23]) are exported.
module fp32_mant_mac #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        load,
    input  logic        step,
    input  logic [23:0] mcand,
    input  logic [23:0] mplr,
    output logic [24:0] prod_hi
);

    logic [47:0] acc_q, acc_d;
    logic [47:0] mcand_q, mcand_d;
    logic [23:0] mplr_q, mplr_d;
    logic [47:0] step_sum;
    logic [47:0] pp [BITS_PER_CYCLE];

    // One shifted copy of the multiplicand per multiplier bit retired this step.
    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
            assign pp[gi] = mplr_q[gi] ? (mcand_q << gi) : 48'd0;
        end
    endgenerate

    // Load clears the accumulator; step adds the partial products and shifts.
    always_comb begin
        step_sum = 48'd0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            step_sum = step_sum + pp[i];
        end
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        if (load) begin
            acc_d   = 48'd0;
            mcand_d = {24'd0, mcand};
            mplr_d  = mplr;
        end else if (step) begin
            acc_d   = acc_q + step_sum;
            mcand_d = mcand_q << BITS_PER_CYCLE;
            mplr_d  = mplr_q >> BITS_PER_CYCLE;
        end
    end

    // Accumulator and operand shift registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            acc_q   <= 48'd0;
            mcand_q <= 48'd0;
            mplr_q  <= 24'd0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
        end
    end

    assign prod_hi = acc_q[47:23];

endmodule

// File: rtl/fp32_mul_seq.sv
// Iterative FP32 multiplier: IDLE -> MUL (24/BITS_PER_CYCLE cycles) -> NORM -> DONE.
// Result is registered on leaving NORM; out_valid is registered one cycle
// later so the accept-to-valid latency is N+2 cycles regardless of data.
// Optional IEEE special handling (NaN/inf) is enabled by FP32_MUL_SPECIALS_EN.
module fp32_mul_seq
    import fp32_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    localparam int         N        = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] CNT_LAST = 5'(N - 1);

    fp32_mul_state_e   state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic              zero_q, zero_d;
    logic signed [9:0] exp_sum_q, exp_sum_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       result_q, result_d;
`ifdef FP32_MUL_SPECIALS_EN
    logic              nan_q, nan_d;
    logic              inf_q, inf_d;
`endif

    fp32_t             a_f, b_f, res_f;
    logic              accept, mac_step;
    logic [24:0]       prod_hi;
    logic signed [9:0] exp_fin;
    logic [22:0]       frac_n;

    assign a_f      = a;
    assign b_f      = b;
    assign in_ready = (state_q == IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign mac_step = (state_q == MUL);

    fp32_mant_mac #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_mac (
        .clk     (clk),
        .srst    (reset),
        .load    (accept),
        .step    (mac_step),
        .mcand   ({|a_f.exp, a_f.frac}),
        .mplr    ({|b_f.exp, b_f.frac}),
        .prod_hi (prod_hi)
    );

    // Next-state, operand capture, normalisation and packing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        zero_d      = zero_q;
        exp_sum_d   = exp_sum_q;
        result_d    = result_q;
        out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);
`ifdef FP32_MUL_SPECIALS_EN
        nan_d       = nan_q;
        inf_d       = inf_q;
`endif
        exp_fin     = exp_sum_q + {9'd0, prod_hi[24]};
        frac_n      = prod_hi[24] ? prod_hi[23:1] : prod_hi[22:0];
        res_f       = '{sign: sign_q, exp: exp_fin[7:0], frac: frac_n};

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = MUL;
                    cnt_d     = 5'd0;
                    sign_d    = a_f.sign ^ b_f.sign;
                    zero_d    = (a_f.exp == 8'd0) || (b_f.exp == 8'd0);
                    exp_sum_d = $signed({2'b00, a_f.exp}) + $signed({2'b00, b_f.exp})
                                - 10'(FP32_BIAS);
`ifdef FP32_MUL_SPECIALS_EN
                    nan_d = ((a_f.exp == 8'hFF) && (a_f.frac != 23'd0)) ||
                            ((b_f.exp == 8'hFF) && (b_f.frac != 23'd0));
                    inf_d = (a_f.exp == 8'hFF) || (b_f.exp == 8'hFF);
`endif
                end
            end
            MUL: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                state_d = DONE;
`ifdef FP32_MUL_SPECIALS_EN
                if (nan_q || (inf_q && zero_q)) begin
                    result_d = FP32_QNAN;
                end else if (inf_q) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                end else if (zero_q || (exp_fin <= 10'sd0)) begin
                    result_d = {sign_q, 31'd0};
                end else if (exp_fin >= 10'(FP32_EXP_MAX)) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                end else begin
                    result_d = res_f;
                end
`else
                if (zero_q || (exp_fin <= 10'sd0)) begin
                    result_d = {sign_q, 31'd0};
                end else if (exp_fin >= 10'(FP32_EXP_MAX)) begin
                    result_d = {sign_q, FP32_MAX_FIN[30:0]};
                end else begin
                    result_d = res_f;
                end
`endif
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            exp_sum_q   <= 10'sd0;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
`ifdef FP32_MUL_SPECIALS_EN
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
            exp_sum_q   <= exp_sum_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
`ifdef FP32_MUL_SPECIALS_EN
            nan_q       <= nan_d;
            inf_q       <= inf_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Testbench for fp32_mul_seq: directed cases plus randomized operands,
// checked against an arithmetic reference model by a negedge monitor.
module tb_fp32_mul_seq;

    localparam int BPC = 1;
    localparam int LAT = 24 / BPC + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [31:0] exp_q [$];
    int          acc_q [$];
    logic        prev_ov = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] held = 32'd0;
    logic [31:0] last_result = 32'd0;

    fp32_mul_seq #(.BITS_PER_CYCLE(BPC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: real-number product of the two significands, truncated.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
        logic s;
        int ex, ey, e;
        longint unsigned mx, my, p;
        logic [22:0] fr;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
`ifdef FP32_MUL_SPECIALS_EN
        if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return 32'h7FC00000;
        if ((ex == 255 && ey == 0) || (ey == 255 && ex == 0)) return 32'h7FC00000;
        if (ex == 255 || ey == 255) return {s, 8'hFF, 23'd0};
`endif
        if (ex == 0 || ey == 0) return {s, 31'd0};
        mx = 64'(x[22:0]) + 64'h800000;
        my = 64'(y[22:0]) + 64'h800000;
        p  = mx * my;
        e  = ex + ey - 127;
        if (p >= 64'h8000_0000_0000) begin
            fr = 23'((p >> 24) & 64'h7FFFFF);
            e  = e + 1;
        end else begin
            fr = 23'((p >> 23) & 64'h7FFFFF);
        end
        if (e <= 0) return {s, 31'd0};
`ifdef FP32_MUL_SPECIALS_EN
        if (e >= 255) return {s, 8'hFF, 23'd0};
`else
        if (e >= 255) return {s, 31'h7F7FFFFF};
`endif
        return {s, 8'(e), fr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Compare process: latency, hold stability, ready/busy, result vs model.
    always @(negedge clk) begin
        if (!reset) begin
            tests++;
            if (in_ready !== !busy) begin
                fails++;
                $display("FAIL ready_busy: in_ready=%b busy=%b", in_ready, busy);
            end
            if (prev_hold) begin
                tests++;
                if (out_valid !== 1'b1 || result !== held) begin
                    fails++;
                    $display("FAIL hold_stable: out_valid=%b result=%h expected 1 %h", out_valid, result, held);
                end
            end
            if (out_valid && !prev_ov) begin
                tests++;
                if (acc_q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_valid: out_valid=1 with no transaction outstanding");
                end else begin
                    int lat;
                    lat = cyc - acc_q.pop_front();
                    if (lat != LAT) begin
                        fails++;
                        $display("FAIL latency: got %0d expected %0d", lat, LAT);
                    end
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL result: unexpected result %h", result);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("result", result, e);
                    $display("[TB] txn result=%h expected=%h", result, e);
                end
                last_result = result;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b));
                acc_q.push_back(cyc + 1);
            end
            prev_ov   = out_valid;
            prev_hold = out_valid && !out_ready;
            held      = result;
        end else begin
            prev_ov   = 1'b0;
            prev_hold = 1'b0;
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
        end
        in_valid = 1'b1;
        a = x;
        b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 400) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b1;
        if (exp_q.size() != 0 || !in_ready) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: pending=%0d expected 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic run(input string name, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] expv);
        check({"model_", name}, model(x, y), expv);
        send(x, y);
        wait_done(1'b0);
        check({"dut_", name}, last_result, expv);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_release_ready", {31'd0, in_ready}, 32'd1);

        run("1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000);
        run("m3xhalf", 32'hC0400000, 32'h3F000000, 32'hBFC00000);
        run("zero",    32'h00000000, 32'h40490FDB, 32'h00000000);
        run("negzero", 32'h80000000, 32'h3F800000, 32'h80000000);
        run("uflow",   32'h00800000, 32'h3F000000, 32'h00000000);
`ifdef FP32_MUL_SPECIALS_EN
        run("oflow",   32'h7F000000, 32'h40000000, 32'h7F800000);
        run("infx0",   32'h7F800000, 32'h00000000, 32'h7FC00000);
`else
        run("oflow",   32'h7F000000, 32'h40000000, 32'h7F7FFFFF);
        run("noflow",  32'hFF000000, 32'h40000000, 32'hFF7FFFFF);
`endif

        // Back-pressure: hold out_ready low while offering a new operand pair.
        out_ready = 1'b0;
        send(32'h3FC00000, 32'h40000000);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid_seen", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 32'h40000000;
            b = 32'h40000000;
            @(posedge clk); #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_result", result, 32'h40400000);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", {31'd0, out_valid}, 32'd0);
        check("bp_ready_back", {31'd0, in_ready}, 32'd1);
        check("bp_queue_empty", exp_q.size(), 32'd0);

        // Reset in the middle of MUL.
        send(32'h40000000, 32'h40400000);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        exp_q.delete();
        acc_q.delete();
        reset = 1'b0;
        @(posedge clk); #1;
        check("mrst_ready_after", {31'd0, in_ready}, 32'd1);
        repeat (30) @(posedge clk);
        #1;
        check("mrst_no_valid", {31'd0, out_valid}, 32'd0);
        run("one", 32'h3F800000, 32'h3F800000, 32'h3F800000);

        // Randomized operands with random consumer back-pressure.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 != 3) begin
                ra[30:23] = 8'($urandom_range(100, 154));
                rb[30:23] = 8'($urandom_range(100, 154));
            end
            send(ra, rb);
            wait_done(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
